// File: rtl/rotate_cmd_fifo.sv
// Rotate-command FIFO feeding a combinational rotator. A result reaches the registered output one edge after the command is accepted.
// Full FIFO refuses input regardless of out_ready. A stalled output holds its result and the FIFO head stays stable.
module rotate_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [7:0]    in_data,
    input  logic [2:0]    in_amt,
    input  logic          in_dir,
    output logic [7:0]    rot_a,
    output logic [2:0]    rot_s,
    output logic          rot_dir,
    input  logic [7:0]    rot_y,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [7:0]    out_data,
    output logic [AW:0]   count
);

    if (DEPTH < 2 || (1 << AW) != DEPTH) begin : g_bad_param
        $error("rotate_cmd_fifo: DEPTH must be a power of 2 >= 2 and equal 2**AW");
    end

    typedef struct packed {
        logic       dir;
        logic [2:0] amt;
        logic [7:0] data;
    } cmd_t;

    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    cmd_t          mem [DEPTH];
    cmd_t          cmd_in;
    cmd_t          head;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          empty;
    logic          push;
    logic          pop;

    assign cmd_in   = '{dir: in_dir, amt: in_amt, data: in_data};
    assign empty    = (count == '0);
    // in_ready looks only at occupancy so a full FIFO never accepts on a pop cycle.
    assign in_ready = ~rst & (count != FULL_CNT);
    assign push     = in_valid & in_ready;
    assign pop      = ~empty & (~out_valid | out_ready);
    assign head     = mem[rd_ptr];

    always_comb begin
        rot_a   = 8'h00;
        rot_s   = 3'd0;
        rot_dir = 1'b0;
        if (!empty) begin
            rot_a   = head.data;
            rot_s   = head.amt;
            rot_dir = head.dir;
        end
    end

    // Storage is deliberately left unreset; empty entries are never observed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= cmd_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            out_data  <= 8'h00;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr    <= rd_ptr + AW'(1);
                out_valid <= 1'b1;
                out_data  <= rot_y;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            case ({push, pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_rotate_cmd_fifo.sv
// Scoreboarded bench for rotate_cmd_fifo with a behavioural rotator attached to the rot_* ports.
module tb_rotate_cmd_fifo;

    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [7:0]    in_data = 8'h00;
    logic [2:0]    in_amt = 3'd0;
    logic          in_dir = 1'b0;
    logic [7:0]    rot_a;
    logic [2:0]    rot_s;
    logic          rot_dir;
    logic [7:0]    rot_y;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [7:0]    out_data;
    logic [AW:0]   count;

    int checks = 0;
    int passed = 0;
    int accepted = 0;
    logic [7:0] exp_q[$];

    rotate_cmd_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_amt(in_amt), .in_dir(in_dir),
        .rot_a(rot_a), .rot_s(rot_s), .rot_dir(rot_dir), .rot_y(rot_y),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .count(count)
    );

    always #5 clk = ~clk;

    // Rotator stand-in: doubled-word shift.
    logic [15:0] dbl, dbl_l, dbl_r;
    always_comb begin
        dbl   = {rot_a, rot_a};
        dbl_l = dbl << rot_s;
        dbl_r = dbl >> rot_s;
        rot_y = rot_dir ? dbl_l[15:8] : dbl_r[7:0];
    end

    // Reference: bit i of a right rotate by n comes from bit (i+n) mod 8; left from (i-n) mod 8.
    function automatic logic [7:0] ref_rot(input logic [7:0] d, input int n, input logic left);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            if (left) r[i] = d[(i - n + 8) % 8];
            else      r[i] = d[(i + n) % 8];
        end
        return r;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Stimulus side of the scoreboard: every accepted command queues its expected result.
    always @(negedge clk) begin
        if (!rst && in_valid && in_ready) begin
            exp_q.push_back(ref_rot(in_data, int'(in_amt), in_dir));
            accepted++;
        end
    end

    // Monitor: compares each delivered result and verifies stalled outputs hold.
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data  = 8'h00;
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid_hold", int'(out_valid), 1);
                chk("stall_data_hold", int'(out_data), int'(prev_data));
            end
            if (count > 3'(DEPTH)) chk("count_bound", int'(count), DEPTH);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", int'(out_data), -1);
                end else begin
                    chk("result", int'(out_data), int'(exp_q.pop_front()));
                end
            end
            prev_stall = out_valid & ~out_ready;
            prev_data  = out_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents a command and holds it until accepted (bounded).
    task automatic send(input logic [7:0] d, input logic [2:0] a, input logic dir);
        bit ok = 0;
        in_valid = 1'b1; in_data = d; in_amt = a; in_dir = dir;
        for (int c = 0; c < 50 && !ok; c++) begin
            @(negedge clk);
            if (in_ready) ok = 1;
            @(posedge clk);
            #1;
        end
        if (!ok) chk("send_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int c = 0;
        out_ready = 1'b1;
        while ((exp_q.size() != 0 || out_valid) && c < 200) begin
            tick();
            c++;
        end
        chk("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        // Reset state
        @(negedge clk);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_count", int'(count), 0);
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_rot_a", int'(rot_a), 0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", int'(in_ready), 1);
        tick();

        // Single right rotate: latency and exact value
        out_ready = 1'b1;
        send(8'h81, 3'd1, 1'b0);
        @(negedge clk);
        chk("lat_valid_e0", int'(out_valid), 0);
        chk("lat_count_e0", int'(count), 1);
        chk("head_rot_a", int'(rot_a), 8'h81);
        @(negedge clk);
        chk("lat_valid_e1", int'(out_valid), 1);
        chk("ror_81_1", int'(out_data), 8'hC0);
        chk("count_back_0", int'(count), 0);
        drain();

        // Left rotates and amt = 0
        send(8'h81, 3'd3, 1'b1);
        @(negedge clk); @(negedge clk);
        chk("rol_81_3", int'(out_data), 8'h0C);
        send(8'hA5, 3'd0, 1'b1);
        @(negedge clk); @(negedge clk);
        chk("rol_a5_0", int'(out_data), 8'hA5);
        drain();

        // Fill with output blocked: 5 accepted (1 in output register, 4 in FIFO)
        out_ready = 1'b0;
        accepted = 0;
        for (int i = 1; i <= 5; i++) send(8'(i), 3'd1, 1'b1);
        in_valid = 1'b1; in_data = 8'h06; in_amt = 3'd1; in_dir = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        chk("fill_accepted", accepted, 5);
        chk("fill_count", int'(count), DEPTH);
        chk("fill_in_ready", int'(in_ready), 0);
        chk("fill_out_data", int'(out_data), 8'h02);
        // Pop at full: no push that cycle
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("full_pop_count", int'(count), DEPTH);
        chk("full_pop_in_ready", int'(in_ready), 0);
        @(negedge clk);
        chk("after_pop_count", int'(count), DEPTH - 1);
        chk("after_pop_in_ready", int'(in_ready), 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("sixth_accepted", accepted, 6);
        drain();

        // Out_ready pulsed while full
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) send(8'($urandom), 3'($urandom), 1'($urandom));
        in_valid = 1'b1; in_data = 8'h3C; in_amt = 3'd2; in_dir = 1'b0;
        tick();
        out_ready = 1'b1;
        @(negedge clk);
        chk("pulse_count", int'(count), DEPTH);
        chk("pulse_in_ready", int'(in_ready), 0);
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk("pulse_after_count", int'(count), DEPTH - 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        drain();

        // Streaming: one command and one result per clock
        out_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            in_valid = 1'b1;
            in_data = 8'($urandom); in_amt = 3'($urandom); in_dir = 1'($urandom);
            @(negedge clk);
            chk("stream_in_ready", int'(in_ready), 1);
            if (k >= 1) chk("stream_count", int'(count), 1);
            if (k >= 2) chk("stream_out_valid", int'(out_valid), 1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        drain();

        // Random traffic
        for (int k = 0; k < 400; k++) begin
            if (!in_valid || in_ready) begin
                in_valid = 1'($urandom_range(0, 2) != 0);
                in_data = 8'($urandom); in_amt = 3'($urandom); in_dir = 1'($urandom);
            end
            out_ready = 1'($urandom_range(0, 2) == 0);
            @(negedge clk);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        drain();

        // Reset mid-stream with count = 3 and a pending result
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(8'($urandom), 3'($urandom), 1'($urandom));
        @(negedge clk);
        chk("prerst_count", int'(count), 3);
        chk("prerst_out_valid", int'(out_valid), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_out_data", int'(out_data), 0);
        chk("midrst_count", int'(count), 0);
        chk("midrst_in_ready", int'(in_ready), 0);
        exp_q.delete();
        @(negedge clk);
        #2;
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("postrst_in_ready", int'(in_ready), 1);
        repeat (5) tick();
        @(negedge clk);
        chk("postrst_no_stale", int'(out_valid), 0);
        drain();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
